i2c_write_sequencer: RTL and testbench

- Transaction-level I2C master controller for write transfers.
- Accepts a command (7-bit address and byte count) and pulls payload bytes from a valid/ready stream.
- Generates the START and STOP conditions itself and hands each byte (address+W, then data) to the downstream byte transmitter over a start/done/error handshake.
- Owns the bus mux between its own START/STOP drive and the byte transmitter's SDA/SCL outputs; sits between the register/host layer and the I2C pads.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_write_sequencer.sv | 175 +++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write path: sequencer state encoding,
// R/W bit values and the number of tick phases per SCL period.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_A   = 4'd1,
    ST_START_B   = 4'd2,
    ST_START_C   = 4'd3,
    ST_ADDR      = 4'd4,
    ST_DATA_WAIT = 4'd5,
    ST_DATA      = 4'd6,
    ST_STOP_A    = 4'd7,
    ST_STOP_B    = 4'd8,
    ST_STOP_C    = 4'd9,
    ST_DONE      = 4'd10
  } seq_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // i_tick strobes per SCL period
  localparam int TICK_PHASES = 4;

endpackage

// File: rtl/i2c_write_sequencer.sv
// I2C write-transaction sequencer: takes an address/length command, frames
// it with START/STOP, hands address+W and payload bytes to the byte
// transmitter, and muxes pad drive between itself and that transmitter.
module i2c_write_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [6:0]       i_cmd_addr,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic             i_data_valid,
  input  logic [7:0]       i_data,
  output logic             o_data_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_nack,
  output logic [LEN_W-1:0] o_nack_idx,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_data,
  input  logic             i_tx_done,
  input  logic             i_tx_error,
  input  logic             i_byte_sda,
  input  logic             i_byte_scl,
  input  logic             i_byte_sda_disable,
  input  logic             i_byte_scl_disable,
  input  logic             i_scl,
  output logic             o_sda,
  output logic             o_scl,
  output logic             o_sda_disable,
  output logic             o_scl_disable
);

  import i2c_pkg::*;

  seq_state_e       state_q, state_d;
  logic [6:0]       addr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] nack_idx_q;
  logic             nack_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;

  logic accept;
  logic load_addr;
  logic pop;
  logic set_nack;
  logic sda_rel;
  logic scl_rel;
  logic use_byte;

  // State register; reset drops straight to IDLE without a STOP
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake strobes; error takes priority over done
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_addr = 1'b0;
    pop       = 1'b0;
    set_nack  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_START_A;
        end
      end
      ST_START_A:   if (i_tick && i_scl) state_d = ST_START_B;
      ST_START_B:   if (i_tick) state_d = ST_START_C;
      ST_START_C: begin
        if (i_tick) begin
          load_addr = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_tx_error) begin
          set_nack = 1'b1;
          state_d  = ST_STOP_A;
        end else if (i_tx_done) begin
          state_d = (len_q == '0) ? ST_STOP_A : ST_DATA_WAIT;
        end
      end
      ST_DATA_WAIT: begin
        if (i_data_valid) begin
          pop     = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (i_tx_error) begin
          set_nack = 1'b1;
          state_d  = ST_STOP_A;
        end else if (i_tx_done) begin
          state_d = (cnt_q == len_q) ? ST_STOP_A : ST_DATA_WAIT;
        end
      end
      ST_STOP_A:    if (i_tick) state_d = ST_STOP_B;
      ST_STOP_B:    if (i_tick && i_scl) state_d = ST_STOP_C;
      ST_STOP_C:    if (i_tick) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Line levels the sequencer wants per state; ADDR/DATA defer to the byte transmitter
  always_comb begin
    sda_rel  = 1'b1;
    scl_rel  = 1'b1;
    use_byte = 1'b0;
    case (state_q)
      ST_START_B:   begin sda_rel = 1'b0; scl_rel = 1'b1; end
      ST_START_C:   begin sda_rel = 1'b0; scl_rel = 1'b0; end
      ST_ADDR:      use_byte = 1'b1;
      ST_DATA:      use_byte = 1'b1;
      ST_DATA_WAIT: begin sda_rel = 1'b0; scl_rel = 1'b0; end
      ST_STOP_A:    begin sda_rel = 1'b0; scl_rel = 1'b0; end
      ST_STOP_B:    begin sda_rel = 1'b0; scl_rel = 1'b1; end
      default:      begin sda_rel = 1'b1; scl_rel = 1'b1; end
    endcase
  end

  // Command latch, byte counter, NACK record and transmitter byte/strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      nack_q     <= 1'b0;
      nack_idx_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= load_addr | pop;
      if (accept) begin
        addr_q     <= i_cmd_addr;
        len_q      <= i_cmd_len;
        cnt_q      <= '0;
        nack_q     <= 1'b0;
        nack_idx_q <= '0;
      end
      if (load_addr) tx_data_q <= {addr_q, I2C_RW_WRITE};
      if (pop) begin
        tx_data_q <= i_data;
        cnt_q     <= cnt_q + LEN_W'(1);
      end
      if (set_nack) begin
        nack_q     <= 1'b1;
        nack_idx_q <= (state_q == ST_ADDR) ? '0 : cnt_q;
      end
    end
  end

  assign o_cmd_ready   = (state_q == ST_IDLE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_data_ready  = pop;
  assign o_nack        = nack_q;
  assign o_nack_idx    = nack_idx_q;
  assign o_tx_start    = tx_start_q;
  assign o_tx_data     = tx_data_q;

  assign o_sda         = use_byte ? i_byte_sda         : sda_rel;
  assign o_scl         = use_byte ? i_byte_scl         : scl_rel;
  assign o_sda_disable = use_byte ? i_byte_sda_disable : sda_rel;
  assign o_scl_disable = use_byte ? i_byte_scl_disable : scl_rel;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer: the bench plays the byte
// transmitter, the payload source and the slave's SCL stretching.
module tb_i2c_write_sequencer;

  localparam int LEN_W = 8;

  logic             clk;
  logic             i_rst_n;
  logic             i_tick;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [6:0]       i_cmd_addr;
  logic [LEN_W-1:0] i_cmd_len;
  logic             i_data_valid;
  logic [7:0]       i_data;
  logic             o_data_ready;
  logic             o_busy;
  logic             o_done;
  logic             o_nack;
  logic [LEN_W-1:0] o_nack_idx;
  logic             o_tx_start;
  logic [7:0]       o_tx_data;
  logic             i_tx_done;
  logic             i_tx_error;
  logic             i_byte_sda;
  logic             i_byte_scl;
  logic             i_byte_sda_disable;
  logic             i_byte_scl_disable;
  logic             i_scl;
  logic             o_sda;
  logic             o_scl;
  logic             o_sda_disable;
  logic             o_scl_disable;

  logic             stretch;
  logic [7:0]       pay [0:255];

  int total = 0;
  int bad   = 0;
  int pop_cnt = 0, txs_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic prev_sda = 1'b1, prev_scl = 1'b1;

  i2c_write_sequencer #(.LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_tick(i_tick),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
    .o_busy(o_busy), .o_done(o_done), .o_nack(o_nack), .o_nack_idx(o_nack_idx),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_done(i_tx_done), .i_tx_error(i_tx_error),
    .i_byte_sda(i_byte_sda), .i_byte_scl(i_byte_scl),
    .i_byte_sda_disable(i_byte_sda_disable), .i_byte_scl_disable(i_byte_scl_disable),
    .i_scl(i_scl), .o_sda(o_sda), .o_scl(o_scl),
    .o_sda_disable(o_sda_disable), .o_scl_disable(o_scl_disable)
  );

  // Open-drain SCL as the bench sees it, with optional slave stretching
  assign i_scl = o_scl_disable & ~stretch;

  wire sda_line = o_sda_disable ? 1'b1 : o_sda;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-in-four tick strobe
  initial begin
    int tcnt;
    tcnt   = 0;
    i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt   = (tcnt + 1) % 4;
      i_tick = (tcnt == 0);
    end
  end

  // Bus monitor: START/STOP conditions, pops and transmitter strobes
  always @(negedge clk) begin
    if (prev_scl && i_scl && prev_sda && !sda_line) start_cnt <= start_cnt + 1;
    if (prev_scl && i_scl && !prev_sda && sda_line) stop_cnt  <= stop_cnt + 1;
    if (o_data_ready) pop_cnt <= pop_cnt + 1;
    if (o_tx_start)   txs_cnt <= txs_cnt + 1;
    prev_sda <= sda_line;
    prev_scl <= i_scl;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tx_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (o_tx_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // One full transaction; nack_at = -1 for all-ACK, 0 for address, k for data byte k
  task automatic run_txn(input logic [6:0] addr, input int len, input int nack_at,
                         input int gap_ticks, input int stretch_ticks);
    int   last, pops0, txs0, starts0, stops0, gtx0;
    logic [7:0] exp_b;
    bit   seen, ok;
    last    = (nack_at >= 0) ? nack_at : len;
    pops0   = pop_cnt;
    txs0    = txs_cnt;
    starts0 = start_cnt;
    stops0  = stop_cnt;
    i_cmd_addr  = addr;
    i_cmd_len   = len[LEN_W-1:0];
    i_cmd_valid = 1'b1;
    check("cmd_ready_idle", o_cmd_ready, 1);
    step();
    i_cmd_valid = 1'b0;
    check("busy_after_accept", o_busy, 1);
    for (int b = 0; b <= last; b++) begin
      exp_b = (b == 0) ? {addr, 1'b0} : pay[b];
      if (b > 0) begin
        if (gap_ticks > 0) begin
          gtx0 = txs_cnt;
          ok   = 1'b1;
          repeat (gap_ticks * 4) begin
            step();
            if (!(o_scl_disable === 1'b0 && o_scl === 1'b0 && o_sda_disable === 1'b0)) ok = 1'b0;
          end
          check("gap_lines_low", ok, 1);
          check("gap_no_tx_start", txs_cnt - gtx0, 0);
        end
        i_data       = pay[b];
        i_data_valid = 1'b1;
      end
      wait_tx_start(seen);
      i_data_valid = 1'b0;
      check("tx_start_seen", seen, 1);
      check("tx_byte", o_tx_data, exp_b);
      if (b == 0) begin
        check("mux_sda_dis", o_sda_disable, 1);
        check("mux_scl_dis", o_scl_disable, 0);
      end
      repeat (5) step();
      if (b == nack_at) i_tx_error = 1'b1;
      else              i_tx_done  = 1'b1;
      step();
      i_tx_error = 1'b0;
      i_tx_done  = 1'b0;
    end
    if (stretch_ticks > 0) begin
      stretch = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (o_scl_disable === 1'b1 && o_sda_disable === 1'b0) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      check("reach_stop_b", seen, 1);
      ok = 1'b1;
      repeat (stretch_ticks * 4) begin
        step();
        if (o_done === 1'b1 || o_sda_disable !== 1'b0) ok = 1'b0;
      end
      check("stop_held_while_stretched", ok, 1);
      stretch = 1'b0;
    end
    wait_done(seen);
    check("done_seen", seen, 1);
    check("nack", o_nack, (nack_at >= 0) ? 1 : 0);
    check("nack_idx", o_nack_idx, (nack_at >= 0) ? nack_at : 0);
    check("pop_count", pop_cnt - pops0, last);
    check("tx_start_count", txs_cnt - txs0, last + 1);
    check("start_cond_count", start_cnt - starts0, 1);
    check("stop_cond_count", stop_cnt - stops0, 1);
    step();
    check("ready_after_done", o_cmd_ready, 1);
    check("busy_after_done", o_busy, 0);
    check("nack_held", o_nack, (nack_at >= 0) ? 1 : 0);
  endtask

  initial begin
    bit seen;
    int stops0;
    i_rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
    i_data_valid = 1'b0; i_data = '0;
    i_tx_done = 1'b0; i_tx_error = 1'b0;
    i_byte_sda = 1'b1; i_byte_scl = 1'b0;
    i_byte_sda_disable = 1'b1; i_byte_scl_disable = 1'b0;
    stretch = 1'b0;
    for (int i = 0; i < 256; i++) pay[i] = 8'(i) ^ 8'h5A;

    repeat (3) step();
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_sda_dis", o_sda_disable, 1);
    check("rst_scl_dis", o_scl_disable, 1);
    check("rst_sda", o_sda, 1);
    check("rst_scl", o_scl, 1);
    check("rst_done", o_done, 0);
    check("rst_nack", o_nack, 0);
    check("rst_nack_idx", o_nack_idx, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_data_ready", o_data_ready, 0);
    i_rst_n = 1'b1;
    repeat (2) step();

    pay[1] = 8'hA5; pay[2] = 8'h3C;
    run_txn(7'h50, 2, -1, 0, 0);

    run_txn(7'h21, 0, -1, 0, 0);

    pay[1] = 8'h11; pay[2] = 8'h22; pay[3] = 8'h33;
    run_txn(7'h50, 3, 2, 0, 0);

    run_txn(7'h1A, 4, 0, 0, 0);

    pay[1] = 8'h5B; pay[2] = 8'hC3;
    run_txn(7'h50, 2, -1, 50, 0);

    pay[1] = 8'h96;
    run_txn(7'h2C, 1, -1, 0, 10);

    for (int i = 0; i < 256; i++) pay[i] = 8'(i) ^ 8'h5A;
    run_txn(7'h7F, 255, -1, 0, 0);

    // Reset while the first data byte is in flight
    i_cmd_addr = 7'h33; i_cmd_len = 8'd2; i_cmd_valid = 1'b1;
    step();
    i_cmd_valid = 1'b0;
    wait_tx_start(seen);
    check("rst_run_addr_start", seen, 1);
    repeat (3) step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    i_data = 8'h77; i_data_valid = 1'b1;
    wait_tx_start(seen);
    i_data_valid = 1'b0;
    check("rst_run_data_byte", o_tx_data, 8'h77);
    stops0 = stop_cnt;
    repeat (2) step();
    check("rst_run_busy_before", o_busy, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_busy", o_busy, 0);
    check("async_rst_sda_dis", o_sda_disable, 1);
    check("async_rst_scl_dis", o_scl_disable, 1);
    check("async_rst_ready", o_cmd_ready, 1);
    repeat (2) step();
    i_rst_n = 1'b1;
    step();
    check("no_stop_on_reset", stop_cnt - stops0, 0);
    check("rst_clears_tx_data", o_tx_data, 0);

    run_txn(7'h21, 0, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
